// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// datapath select codes, ALU control codes and data-processing cmd values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_UNDEF
    } state_t;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_ORR    = 2'b11;

    localparam logic [3:0] CMD_ADD    = 4'b0100;
    localparam logic [3:0] CMD_SUB    = 4'b0010;
    localparam logic [3:0] CMD_AND    = 4'b0000;
    localparam logic [3:0] CMD_ORR    = 4'b1100;
    localparam logic [3:0] CMD_CMP    = 4'b1010;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BR      = 2'b10;

    // Raw per-state strobes/selects; write strobes are gated by CondExL in the top.
    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] ressrc;
        logic [1:0] aluctl;
    } ctrl_t;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
               (cmd == CMD_ORR) || (cmd == CMD_CMP);
    endfunction

    function automatic logic [1:0] alu_op(input logic [3:0] cmd);
        logic [1:0] v;
        v = ALU_ADD;
        case (cmd)
            CMD_SUB, CMD_CMP: v = ALU_SUB;
            CMD_AND:          v = ALU_AND;
            CMD_ORR:          v = ALU_ORR;
            default:          v = ALU_ADD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mc_condlogic.sv
// Flags register, condition evaluation against Cond, and CondExL latched at
// the end of DECODE; flag writes are suppressed when the condition failed.
module mc_condlogic
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_latch,
    input  logic [1:0] i_flag_w,
    output logic       o_condexl
);

    logic [3:0] r_flags;
    logic       r_condexl;
    logic       w_condex;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_condex = 1'b0;
        case (i_cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = w_c & ~w_z;
            4'b1001: w_condex = ~w_c | w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = ~w_z & (w_n == w_v);
            4'b1101: w_condex = w_z | (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags   <= 4'b0000;
            r_condexl <= 1'b0;
        end else begin
            if (i_latch)
                r_condexl <= w_condex;
            if (i_flag_w[1] && r_condexl)
                r_flags[3:2] <= i_alu_flags[3:2];
            if (i_flag_w[0] && r_condexl)
                r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    assign o_condexl = r_condexl;

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: FSM with registered Moore selects, instruction decoder,
// condition gating of writes. Optional undefined-instruction trap: MC_CTRL_UNDEF_TRAP_EN.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic        Undef
);

    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_funct5;
    logic       w_funct0;
    logic       w_rd_pc;
    logic       w_nowrite;
    logic       w_exec;
    logic [1:0] w_flag_w;
    logic       w_condexl;
    logic       w_unused;

    assign w_cond    = Instr[31:28];
    assign w_op      = Instr[27:26];
    assign w_funct5  = Instr[25];
    assign w_cmd     = Instr[24:21];
    assign w_funct0  = Instr[20];
    assign w_rd_pc   = (Instr[15:12] == 4'hF);
    assign w_unused  = ^{Instr[19:16], Instr[11:0]};
    assign w_nowrite = (w_op == OP_DP) && (w_cmd == CMD_CMP);

    function automatic state_t decode_next(input logic [1:0] op, input logic [3:0] cmd,
                                           input logic funct5);
        state_t s;
`ifdef MC_CTRL_UNDEF_TRAP_EN
        s = S_UNDEF;
`else
        s = S_FETCH;
`endif
        case (op)
            OP_MEM:  s = S_MEMADR;
            OP_BR:   s = S_BRANCH;
            OP_DP:   if (cmd_supported(cmd)) s = funct5 ? S_EXECUTEI : S_EXECUTER;
            default: ;
        endcase
        return s;
    endfunction

    function automatic ctrl_t ctrl_of(input state_t s, input logic [3:0] cmd);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pcw = 1'b1; c.irw = 1'b1;
                c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.ressrc = RES_ALURES;
            end
            S_DECODE: begin
                c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.ressrc = RES_ALURES;
            end
            S_MEMADR:   c.alusrcb = SRCB_IMM;
            S_MEMRD:    c.adrsrc = 1'b1;
            S_MEMWR:    begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            S_MEMWB:    begin c.ressrc = RES_DATA; c.regw = 1'b1; end
            S_EXECUTER: c.aluctl = alu_op(cmd);
            S_EXECUTEI: begin c.alusrcb = SRCB_IMM; c.aluctl = alu_op(cmd); end
            S_ALUWB:    c.regw = 1'b1;
            S_BRANCH: begin
                c.alusrcb = SRCB_IMM; c.ressrc = RES_ALURES; c.branch = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:                w_next = S_DECODE;
            S_DECODE:               w_next = decode_next(w_op, w_cmd, w_funct5);
            S_MEMADR:               w_next = w_funct0 ? S_MEMRD : S_MEMWR;
            S_MEMRD:                w_next = S_MEMWB;
            S_EXECUTER, S_EXECUTEI: w_next = S_ALUWB;
            S_UNDEF:                w_next = S_UNDEF;
            default:                w_next = S_FETCH;
        endcase
    end

    // Outputs are registered alongside the state so they are glitch-free Moore values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_of(S_FETCH, CMD_ADD);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next, w_cmd);
        end
    end

    assign w_exec      = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
    assign w_flag_w[1] = w_exec & w_funct0;
    assign w_flag_w[0] = w_flag_w[1] &
                         ((w_cmd == CMD_ADD) || (w_cmd == CMD_SUB) || (w_cmd == CMD_CMP));

    mc_condlogic u_condlogic (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_cond      (w_cond),
        .i_alu_flags (ALUFlags),
        .i_latch     (r_state == S_DECODE),
        .i_flag_w    (w_flag_w),
        .o_condexl   (w_condexl)
    );

    // Strobes are qualified by reset so nothing writes while it is held low.
    assign IRWrite  = reset & r_ctrl.irw;
    assign MemWrite = reset & r_ctrl.memw & w_condexl;
    assign RegWrite = reset & r_ctrl.regw & w_condexl & ~w_nowrite;
    assign PCWrite  = reset & (r_ctrl.pcw |
                      (w_condexl & (r_ctrl.branch | (r_ctrl.regw & w_rd_pc & ~w_nowrite))));

    assign AdrSrc     = r_ctrl.adrsrc;
    assign ALUSrcA    = r_ctrl.alusrca;
    assign ALUSrcB    = r_ctrl.alusrcb;
    assign ResultSrc  = r_ctrl.ressrc;
    assign ALUControl = r_ctrl.aluctl;
    assign ImmSrc     = w_op;
    assign RegSrc     = {w_op == OP_MEM, w_op == OP_BR};

`ifdef MC_CTRL_UNDEF_TRAP_EN
    assign Undef = (r_state == S_UNDEF);
`else
    assign Undef = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboarded bench for mc_controller: per-cycle expected outputs are queued with
// their stimulus and compared as the controller walks each instruction.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Undef;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [13:0] exp_t;
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        exp_t        e;
        string       tag;
    } ent_t;

    ent_t sb_q[$];
    exp_t w_obs;

    assign w_obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                    ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Undef};

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Undef      (Undef)
    );

    always #5 clk = ~clk;

    // Fields: PCWrite MemWrite RegWrite IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc ALUControl Undef
    function automatic exp_t ev(input logic pcw, input logic memw, input logic regw,
                                input logic irw, input logic adr, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] r,
                                input logic [1:0] alu, input logic und);
        return {pcw, memw, regw, irw, adr, a, b, r, alu, und};
    endfunction

    function automatic exp_t e_f();
        return ev(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00, 0);
    endfunction
    function automatic exp_t e_d();
        return ev(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 0);
    endfunction
    function automatic exp_t e_ma();
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0);
    endfunction
    function automatic exp_t e_u();
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    endfunction

    task automatic q(input logic [31:0] i, input logic [3:0] f, input string t, input exp_t e);
        ent_t x;
        x.instr = i; x.flags = f; x.e = e; x.tag = t;
        sb_q.push_back(x);
    endtask

    task automatic q_dp(input logic [31:0] i, input logic [3:0] f, input string t,
                        input logic imm, input logic [1:0] alu, input logic regw,
                        input logic pcw);
        q(i, f, {t, ".F"}, e_f());
        q(i, f, {t, ".D"}, e_d());
        q(i, f, {t, ".EX"}, ev(0, 0, 0, 0, 0, 2'b00, imm ? 2'b01 : 2'b00, 2'b00, alu, 0));
        q(i, f, {t, ".WB"}, ev(pcw, 0, regw, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    endtask

    task automatic q_br(input logic [31:0] i, input string t, input logic pcw);
        q(i, 4'h0, {t, ".F"}, e_f());
        q(i, 4'h0, {t, ".D"}, e_d());
        q(i, 4'h0, {t, ".BR"}, ev(pcw, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0));
    endtask

    task automatic test_reset();
        reset = 1'b0; Instr = 32'hE0821003; ALUFlags = 4'h0;
        #2;
        n_checks++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite, Undef} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset.strobes: observed %b required 00000",
                     {PCWrite, MemWrite, RegWrite, IRWrite, Undef});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset.held: observed %b required 0000",
                     {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== e_f()) begin
            n_fail++;
            $display("FAIL reset.first_fetch: observed %b required %b", w_obs, e_f());
        end
    endtask

    task automatic test_alu_ops();
        ent_t x;
        q_dp(32'hE0821003, 4'h0, "add",    0, 2'b00, 1, 0);
        q_dp(32'hE2821005, 4'h0, "addi",   1, 2'b00, 1, 0);
        q_dp(32'hE0021003, 4'h0, "and",    0, 2'b10, 1, 0);
        q_dp(32'hE1821003, 4'h0, "orr",    0, 2'b11, 1, 0);
        q_dp(32'hE082F003, 4'h0, "add_pc", 0, 2'b00, 1, 1);
        q_dp(32'hF0821003, 4'h0, "add_nv", 0, 2'b00, 0, 0);
        q_dp(32'h00821003, 4'h0, "addeq",  0, 2'b00, 0, 0);
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_branch();
        ent_t x;
        q_dp(32'hE0500001, 4'b0110, "subs_z", 0, 2'b01, 1, 0);
        q_br(32'h0A000002, "beq_taken", 1);
        q_dp(32'hE0500001, 4'b0000, "subs_nz", 0, 2'b01, 1, 0);
        q_br(32'h0A000002, "beq_not", 0);
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if ({RegSrc, ImmSrc} !== 4'b0110) begin
            n_fail++;
            $display("FAIL beq.regsrc_immsrc: observed %b required 0110", {RegSrc, ImmSrc});
        end
    endtask

    task automatic test_mem();
        ent_t x;
        q(32'hE5954008, 4'h0, "ldr.F",   e_f());
        q(32'hE5954008, 4'h0, "ldr.D",   e_d());
        q(32'hE5954008, 4'h0, "ldr.MA",  e_ma());
        q(32'hE5954008, 4'h0, "ldr.MR",  ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        q(32'hE5954008, 4'h0, "ldr.MWB", ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0));
        q(32'hE5854008, 4'h0, "str.F",   e_f());
        q(32'hE5854008, 4'h0, "str.D",   e_d());
        q(32'hE5854008, 4'h0, "str.MA",  e_ma());
        q(32'hE5854008, 4'h0, "str.MW",  ev(0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if ({RegSrc, ImmSrc} !== 4'b1001) begin
            n_fail++;
            $display("FAIL str.regsrc_immsrc: observed %b required 1001", {RegSrc, ImmSrc});
        end
    endtask

    task automatic test_cmp_flags();
        ent_t x;
        q_dp(32'hE1510002, 4'b1000, "cmp",   0, 2'b01, 0, 0);
        q_dp(32'h40821003, 4'b0000, "addmi", 0, 2'b00, 1, 0);
        q_dp(32'h00821003, 4'b0000, "addeq", 0, 2'b00, 0, 0);
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        ent_t x;
        q(32'hE5954008, 4'h0, "ldr_rst.F",  e_f());
        q(32'hE5954008, 4'h0, "ldr_rst.D",  e_d());
        q(32'hE5954008, 4'h0, "ldr_rst.MA", e_ma());
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (AdrSrc !== 1'b1) begin
            n_fail++;
            $display("FAIL ldr_rst.in_memrd: observed AdrSrc=%b required 1", AdrSrc);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc} !== 7'b0000010) begin
            n_fail++;
            $display("FAIL ldr_rst.abort: observed %b required 0000010",
                     {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0) begin
            n_fail++;
            $display("FAIL ldr_rst.held: observed %b required 0000",
                     {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({PCWrite, IRWrite} !== 2'b11) begin
            n_fail++;
            $display("FAIL ldr_rst.release: observed %b required 11", {PCWrite, IRWrite});
        end
        // N was set by the earlier CMP; reset must have cleared it.
        q_br(32'h4A000002, "bmi_after_rst", 0);
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_undef();
        ent_t x;
        q(32'hEC000000, 4'h0, "op11.F", e_f());
        q(32'hEC000000, 4'h0, "op11.D", e_d());
`ifdef MC_CTRL_UNDEF_TRAP_EN
        q(32'hEC000000, 4'h0, "op11.U0", e_u());
        q(32'hEC000000, 4'h0, "op11.U1", e_u());
        q(32'hEC000000, 4'h0, "op11.U2", e_u());
`else
        q(32'hEC000000, 4'h0, "op11.F2", e_f());
        q(32'hEC000000, 4'h0, "op11.D2", e_d());
        q(32'hE0221003, 4'h0, "eor.F",   e_f());
        q(32'hE0221003, 4'h0, "eor.D",   e_d());
        q_dp(32'hE0821003, 4'h0, "add_after_nop", 0, 2'b00, 1, 0);
`endif
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
`ifdef MC_CTRL_UNDEF_TRAP_EN
        reset = 1'b0; #1;
        n_checks++;
        if (Undef !== 1'b0) begin
            n_fail++;
            $display("FAIL undef.reset_clears: observed %b required 0", Undef);
        end
        reset = 1'b1;
        q(32'hE0221003, 4'h0, "eor.F", e_f());
        q(32'hE0221003, 4'h0, "eor.D", e_d());
        q(32'hE0221003, 4'h0, "eor.U", e_u());
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            Instr = x.instr; ALUFlags = x.flags; #1;
            n_checks++;
            if (w_obs !== x.e) begin
                n_fail++;
                $display("FAIL %s: observed %b required %b", x.tag, w_obs, x.e);
            end
            @(negedge clk); #1;
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_mem();
        test_cmp_flags();
        test_reset_mid();
        test_undef();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Instr  in  32  instruction register contents; bits [31:12] used (Cond, Op, Funct, Rd).
REQ-005 ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in the execute cycle.
REQ-006 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath strobes and selects.
REQ-007 RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl  out  2 each  datapath selects.
REQ-008 Undef  out  1  undefined-instruction trap indicator.

Function
REQ-009 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNDEF.
REQ-010 Transitions: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECUTER (Op=00, Funct[5]=0), EXECUTEI (Op=00, Funct[5]=1), BRANCH (Op=10); MEMADR->MEMRD (Funct[0]=1) else MEMWR; MEMRD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-011 Latency SHALL be LDR 5, STR 4, data-processing 4, B 3 cycles.
REQ-012 Selects are Moore outputs; encodings: ALUSrcA 00=A, 01=PC; ALUSrcB 00=reg, 01=ExtImm, 10=constant 4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, add, PCWrite=1 unconditionally.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, add. MEMADR: ALUSrcA=00, ALUSrcB=01, add. MEMRD/MEMWR: AdrSrc=1, ResultSrc=00. MEMWB: ResultSrc=01, RegW. EXECUTER: ALUSrcB=00, decoded op. EXECUTEI: ALUSrcB=01, decoded op. ALUWB: ResultSrc=00, RegW. BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, add.
REQ-015 Decoded op: cmd 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11, 1010 CMP->01 with NoWrite; any other cmd is unsupported.
REQ-016 ImmSrc=Instr[27:26]; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01); combinational from Instr.
REQ-017 CondEx is evaluated from Cond and the internal Flags register (EQ..AL, 15 codes; 1111 false) and latched as CondExL at the end of DECODE.
REQ-018 Flags[3:2] SHALL update from ALUFlags at the end of EXECUTER/EXECUTEI when S=1 and CondExL; Flags[1:0] only if additionally cmd is ADD, SUB or CMP.
REQ-019 RegWrite = RegW & CondExL & ~NoWrite; MemWrite = (state==MEMWR) & CondExL.
REQ-020 PCWrite outside FETCH = CondExL & (state==BRANCH | (RegWrite-state with Rd==15 and not NoWrite)).
REQ-021 A failed condition still walks the full state sequence with all writes suppressed.

Reset
REQ-022 reset low SHALL asynchronously force state=FETCH, Flags=0000, CondExL=0, Undef=0.
REQ-023 While reset is low, PCWrite, MemWrite, RegWrite and IRWrite SHALL be 0; a reset mid-instruction abandons it with no further writes.
REQ-024 The first rising edge after reset release SHALL perform FETCH.

Configuration
REQ-025 MC_CTRL_UNDEF_TRAP_EN defined: DECODE with Op=11 or unsupported cmd -> UNDEF; UNDEF holds, Undef=1, all write enables 0, until reset.
REQ-026 MC_CTRL_UNDEF_TRAP_EN undefined: those encodings go DECODE->FETCH as a NOP; Undef is tied 0; UNDEF is unreachable.

Structure
REQ-027 Package mc_ctrl_pkg SHALL hold the state enum, ALUSrcA/ALUSrcB/ResultSrc encodings, ALUControl codes and cmd codes.
REQ-028 Sub-module mc_condlogic SHALL hold Flags, the CondEx evaluation and CondExL; the FSM and decoder stay in mc_controller.

Verification
REQ-029 Reset low during MEMRD of LDR -> state FETCH, all write enables 0 immediately; after release, IRWrite=1, PCWrite=1 in the first cycle.
REQ-030 ADD R1,R2,R3 (0xE0821003) -> FETCH, DECODE, EXECUTER (ALUControl=00), ALUWB (RegWrite=1 only here).
REQ-031 SUBS with ALUFlags=0110, then BEQ (0x0A000002) -> PCWrite=1 in BRANCH; repeat with ALUFlags=0000 -> PCWrite=0 in BRANCH.
REQ-032 LDR R4,[R5,#8] (0xE5954008) -> 5 cycles, AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB; STR (0xE5854008) -> MemWrite=1 only in MEMWR.
REQ-033 CMP R1,R2 (0xE1510002) with ALUFlags=1000 -> RegWrite=0 in ALUWB, Flags=1000 afterward.
REQ-034 0xEC000000 -> with the macro, UNDEF and Undef=1 with no writes; without the macro, DECODE->FETCH and no writes.
